// File: rtl/seq_feed_ctrl.sv
// seq_feed_ctrl: feeds a latched bit pattern, MSB first, into the external
// run-length detector. Each bit is strobed with a one-cycle det_en, det_z is
// sampled on the following cycle, and the controller keeps a saturating hit
// count and the index of the first hit.
module seq_feed_ctrl #(
    parameter int PAT_W = 16,
    parameter int CNT_W = 8,
    parameter int DIV   = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             step_mode,
    input  logic             step_pulse,
    input  logic [PAT_W-1:0] pattern,
    input  logic [4:0]       pat_len,
    input  logic             det_z,
    output logic             w,
    output logic             det_en,
    output logic             det_rst_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count,
    output logic [4:0]       first_hit_idx,
    output logic             first_hit_valid
);

    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        SAMPLE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PAT_W-1:0] sreg;
    logic [4:0]       remaining;
    logic [4:0]       idx;
    logic [DIV_W-1:0] divider;
    logic             en_q;
    logic             advance;

    assign busy = (state == LOAD) || (state == RUN) || (state == SAMPLE);
    assign done = (state == DONE);
    assign w    = ((state == RUN) || (state == SAMPLE)) ? sreg[PAT_W-1] : 1'b0;

    // Advance decision; en_q blocks a strobe right after the LOAD strobe so
    // det_en can never be high on two consecutive cycles.
    always_comb begin
        advance = 1'b0;
        if (state == RUN && !en_q) begin
            advance = step_mode ? step_pulse : (divider == DIV_LAST);
        end
    end

    // Next-state and detector strobe decode; abort overrides everything.
    always_comb begin
        state_nxt = state;
        det_en    = 1'b0;
        det_rst_n = 1'b1;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD: begin
                det_en    = 1'b1;
                det_rst_n = 1'b0;
                state_nxt = RUN;
            end
            RUN: begin
                if (advance) begin
                    det_en    = 1'b1;
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE:  state_nxt = (remaining == 5'd1) ? DONE : RUN;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            det_en    = 1'b0;
            det_rst_n = 1'b1;
        end
    end

    // State register plus a one-cycle history of det_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            en_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            en_q  <= det_en;
        end
    end

    // Pattern shifter, bit counters, divider and hit bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg            <= '0;
            remaining       <= '0;
            idx             <= '0;
            divider         <= '0;
            hit_count       <= '0;
            first_hit_idx   <= '0;
            first_hit_valid <= 1'b0;
        end else if (!abort) begin
            case (state)
                LOAD: begin
                    sreg            <= pattern;
                    remaining       <= (pat_len == 5'd0) ? 5'd16 : pat_len;
                    idx             <= '0;
                    divider         <= '0;
                    hit_count       <= '0;
                    first_hit_idx   <= '0;
                    first_hit_valid <= 1'b0;
                end
                RUN: begin
                    // Manual mode holds the divider at zero, so switching
                    // modes mid-run always restarts the auto interval.
                    if (advance || step_mode) begin
                        divider <= '0;
                    end else begin
                        divider <= divider + DIV_W'(1);
                    end
                end
                SAMPLE: begin
                    if (det_z) begin
                        if (hit_count != '1) begin
                            hit_count <= hit_count + CNT_W'(1);
                        end
                        if (!first_hit_valid) begin
                            first_hit_idx   <= idx;
                            first_hit_valid <= 1'b1;
                        end
                    end
                    sreg      <= {sreg[PAT_W-2:0], 1'b0};
                    idx       <= idx + 5'd1;
                    remaining <= remaining - 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Testbench for seq_feed_ctrl with a behavioural run-length detector.
module tb_seq_feed_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, step_mode, step_pulse;
    logic [15:0] pattern;
    logic [4:0]  pat_len;
    logic        det_z;
    logic        w, det_en, det_rst_n, busy, done;
    logic [7:0]  hit_count;
    logic [4:0]  first_hit_idx;
    logic        first_hit_valid;

    int checks = 0;
    int errors = 0;

    seq_feed_ctrl #(.PAT_W(16), .CNT_W(8), .DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .step_mode(step_mode), .step_pulse(step_pulse),
        .pattern(pattern), .pat_len(pat_len), .det_z(det_z),
        .w(w), .det_en(det_en), .det_rst_n(det_rst_n), .busy(busy), .done(done),
        .hit_count(hit_count), .first_hit_idx(first_hit_idx),
        .first_hit_valid(first_hit_valid)
    );

    always #5 clk = ~clk;

    // Detector: z=1 once the last four bits received since its reset are equal.
    int   run_len = 0;
    logic last_w  = 1'b0;
    always @(posedge clk) begin
        if (det_en === 1'b1) begin
            if (!det_rst_n) run_len <= 0;
            else begin
                if (run_len != 0 && w == last_w) run_len <= (run_len >= 4) ? 4 : run_len + 1;
                else run_len <= 1;
                last_w <= w;
            end
        end
    end
    assign det_z = (run_len >= 4);

    // Strobe monitor.
    int cyc = 0, bits = 0, rstn_pulses = 0, consec = 0, idle_en = 0;
    int last_bit_cyc = -1, min_gap = 999, max_gap = 0;
    logic prev_en = 1'b0;
    always @(posedge clk) begin
        if (det_en === 1'b1) begin
            if (prev_en) consec++;
            if (!busy) idle_en++;
            if (!det_rst_n) rstn_pulses++;
            else begin
                bits++;
                if (last_bit_cyc >= 0) begin
                    if (cyc - last_bit_cyc < min_gap) min_gap = cyc - last_bit_cyc;
                    if (cyc - last_bit_cyc > max_gap) max_gap = cyc - last_bit_cyc;
                end
                last_bit_cyc = cyc;
            end
        end
        prev_en = (det_en === 1'b1);
        cyc++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected results straight from the run-length rule.
    function automatic void ref_model(input logic [15:0] p, input logic [4:0] l,
                                      output int hits, output int fidx, output int fv);
        int n   = (l == 0) ? 16 : int'(l);
        int run = 0;
        logic prev = 1'b0;
        hits = 0; fidx = 0; fv = 0;
        for (int i = 0; i < n; i++) begin
            logic b = p[15-i];
            run  = (i > 0 && b == prev) ? run + 1 : 1;
            prev = b;
            if (run >= 4) begin
                if (hits < 255) hits++;
                if (fv == 0) begin fidx = i; fv = 1; end
            end
        end
    endfunction

    task automatic clear_mon();
        bits = 0; rstn_pulses = 0; last_bit_cyc = -1; min_gap = 999; max_gap = 0;
    endtask

    task automatic do_run(input logic [15:0] pat, input logic [4:0] len, input logic mode,
                          input bit inject_start, input int hold);
        int hits, fidx, fv, gapc;
        int n = (len == 0) ? 16 : int'(len);
        ref_model(pat, len, hits, fidx, fv);
        pattern = pat; pat_len = len; step_mode = mode;
        clear_mon();
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("load_clears_hits", hit_count, 0);
        chk("load_clears_valid", first_hit_valid, 0);
        chk("load_det_rst", rstn_pulses, 1);
        pattern = 16'($urandom); pat_len = 5'($urandom);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("hold_no_strobe", bits, 0);
            chk("hold_busy", busy, 1);
        end
        gapc = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            step_pulse = mode && (gapc == 0);
            start = inject_start && (c == 7);
            gapc = (gapc == 0) ? 2 + int'($urandom_range(0, 2)) : gapc - 1;
            @(negedge clk);
            step_pulse = 1'b0; start = 1'b0;
        end
        chk("run_done", done, 1);
        chk("run_busy", busy, 0);
        chk("run_w_idle", w, 0);
        chk("run_bits", bits, n);
        chk("run_hits", hit_count, hits);
        chk("run_fvalid", first_hit_valid, fv);
        chk("run_fidx", first_hit_idx, fidx);
        chk("run_rst_pulses", rstn_pulses, 1);
        if (!mode && n >= 2) begin
            chk("auto_min_gap", min_gap, 5);
            chk("auto_max_gap", max_gap, 5);
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; step_mode = 0; step_pulse = 0;
        pattern = '0; pat_len = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_w", w, 0);
        chk("rst_det_en", det_en, 0);
        chk("rst_det_rst_n", det_rst_n, 1);
        chk("rst_hits", hit_count, 0);
        chk("rst_fidx", first_hit_idx, 0);
        chk("rst_fvalid", first_hit_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_run(16'h0000, 5'd0,  1'b0, 1'b0, 0);
        do_run(16'hF0F0, 5'd16, 1'b0, 1'b1, 0);
        do_run(16'hAAAA, 5'd16, 1'b0, 1'b0, 0);
        do_run(16'h0000, 5'd3,  1'b0, 1'b0, 0);
        do_run(16'hFFFF, 5'd4,  1'b1, 1'b0, 50);

        // Manual pulse while DONE does nothing.
        step_pulse = 1'b1; @(negedge clk); step_pulse = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_step_bits", bits, 4);
        chk("done_step_done", done, 1);
        chk("done_step_hits", hit_count, 1);

        for (int r = 0; r < 8; r++)
            do_run(16'($urandom), 5'($urandom_range(0, 16)), 1'($urandom), 1'b0, 0);

        // Abort after six bits of all-zero.
        pattern = 16'h0000; pat_len = 5'd0; step_mode = 1'b0;
        clear_mon();
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200 && bits < 6; c++) @(negedge clk);
        chk("abort_reached6", bits, 6);
        @(negedge clk);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hits", hit_count, 3);
        chk("abort_fidx", first_hit_idx, 3);
        repeat (20) @(negedge clk);
        chk("abort_no_strobe", bits, 6);

        // Asynchronous reset in the middle of a run.
        clear_mon();
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200 && bits < 5; c++) @(negedge clk);
        chk("mid_hits_before", hit_count, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hits", hit_count, 0);
        chk("mid_rst_fvalid", first_hit_valid, 0);
        chk("mid_rst_w", w, 0);
        chk("mid_rst_det_en", det_en, 0);
        @(negedge clk); rst = 1'b1; @(negedge clk);

        do_run(16'hC3FF, 5'd12, 1'b1, 1'b0, 0);

        chk("never_consecutive_en", consec, 0);
        chk("no_en_idle_done", idle_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_feed_ctrl.md
Name: seq_feed_ctrl

Overview:
Controller that sequences the nine-state run-length detector (z=1 after four consecutive equal w bits) from a loaded test pattern, instead of hand-toggled w and button clocks. It latches a pattern from switches and presents one bit per advance on w. It strobes the detector's clock-enable, samples z after every bit, and accumulates a hit count plus the first-hit index for display. It sits between the debounced board inputs (KEY/SW) and the detector, all in the 50 MHz fastclk domain.

Parameters:
PAT_W, 16, pattern width in bits
CNT_W, 8, hit-counter width
DIV, 250000, clk cycles per auto-advance tick (DIV ≥ 2)

Ports:
clk  in  1  50 MHz system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse (debounced); load pattern and run
abort  in  1  one-cycle pulse; return to IDLE
step_mode  in  1  0 = auto advance on divider tick, 1 = advance on step_pulse
step_pulse  in  1  one-cycle pulse (debounced); manual advance
pattern  in  PAT_W  bit sequence, MSB sent first
pat_len  in  5  number of bits to send, 1..16; 0 means 16
det_z  in  1  detector output z
w  out  1  bit to detector
det_en  out  1  one-cycle clock-enable to detector state register
det_rst_n  out  1  detector synchronous reset, active low, valid only with det_en
busy  out  1  high in LOAD/RUN/SAMPLE
done  out  1  high in DONE
hit_count  out  CNT_W  number of bits after which det_z=1, saturating
first_hit_idx  out  5  bit index (0-based) of first hit
first_hit_valid  out  1  first_hit_idx meaningful

Behaviour:
- Reset (rst=0, async): state IDLE; w=0, det_en=0, det_rst_n=1, busy=0, done=0, hit_count=0, first_hit_idx=0, first_hit_valid=0; shift reg, remaining, index and divider all 0.
- States: IDLE, LOAD, RUN, SAMPLE, DONE.
- IDLE: on start → LOAD. Counts hold their last values.
- LOAD (1 cycle):
  - sreg←pattern; remaining←(pat_len==0 ? 16 : pat_len); idx←0.
  - hit_count←0, first_hit_valid←0, first_hit_idx←0, divider←0.
  - det_en=1 and det_rst_n=0 this cycle, so the detector resets to its initial state. → RUN.
- RUN:
  - w = sreg[PAT_W-1] (registered, stable through the whole state).
  - Advance condition: step_mode=0 → divider==DIV-1 (divider counts only in RUN, clears on advance); step_mode=1 → step_pulse. step_pulse is ignored in auto mode.
  - On advance: det_en=1, det_rst_n=1 for exactly that cycle. → SAMPLE.
- SAMPLE (1 cycle; det_z now reflects the bit just sent):
  - If det_z=1: hit_count←hit_count+1, saturating at 2^CNT_W-1. If first_hit_valid=0, also first_hit_idx←idx and first_hit_valid←1.
  - Always: sreg shifts left, filling with 0; idx←idx+1; remaining←remaining-1.
  - If remaining was 1 → DONE, else → RUN.
- DONE: done=1, busy=0, w=0. Outputs hold. start → LOAD (rerun). abort → IDLE.
- det_en is never high in two consecutive cycles. det_en is never high in IDLE or DONE.
- start while busy: ignored.
- abort in any state: → IDLE next cycle with no det_en. Counts keep their partial values. abort has priority over start and over advance in the same cycle.
- Changing step_mode mid-run takes effect at the next RUN cycle and clears the divider.
- Changes to pattern or pat_len after LOAD have no effect until the next start.
- Async reset mid-run: immediate return to reset values. The detector is not reset by this block until the next LOAD.
- Per-bit latency: 1 cycle (step mode, from step_pulse to det_en), or DIV cycles from entering RUN (auto). SAMPLE follows 1 cycle after det_en.

Test Plan:
- DIV=4, step_mode=0, pattern=16'h0000, pat_len=0 → 16 det_en pulses, each 5 cycles apart (4 RUN + 1 SAMPLE). hit_count=13, first_hit_idx=3, first_hit_valid=1, done=1.
- pattern=16'hF0F0, pat_len=16 → hits after idx 3, 7, 11, 15. hit_count=4, first_hit_idx=3.
- pattern=16'hAAAA, pat_len=16 → hit_count=0, first_hit_valid=0, done=1.
- pattern=16'h0000, pat_len=3 → exactly 3 det_en pulses, hit_count=0, done=1. Then start again → LOAD clears counts, det_rst_n=0 pulse seen.
- step_mode=1, pattern=16'hFFFF, pat_len=4 → no det_en without step_pulse (hold 50 cycles). After 4 pulses, hit_count=1, first_hit_idx=3. step_pulse in DONE does nothing.
- Abort after 6 bits of 16'h0000 → IDLE, hit_count=3, no further det_en. start during RUN is ignored. rst low mid-RUN → all outputs at reset values asynchronously.
